calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Multi-cycle instruction sequencer for the calculator processor.
- Fetches 32-bit instructions from instruction memory and holds each one stable for the combinational control decoder.
- Steps each instruction through decode, execute/memory and writeback, handshaking with the multi-cycle ULA for divide and multiply.
- Qualifies the decoder's memory and register-write strobes so each fires exactly once per instruction.

Parameters:
PC_WIDTH, 8, width of program counter and instruction address.
ULA_TIMEOUT, 64, max WAIT_ULA cycles before declaring an error (>=2).

Ports:
_clock  input  1  system clock, rising edge.
_reset  input  1  asynchronous, active-high reset.
_start  input  1  begin execution at address 0; honoured only in IDLE or HALT.
_imem_addr  output  PC_WIDTH  instruction fetch address (= _pc).
_imem_req  output  1  fetch request; high throughout FETCH.
_imem_valid  input  1  fetch data valid; sampled only in FETCH.
_imem_data  input  32  fetched instruction.
_instrucao  output  32  latched current instruction, fed to the control decoder.
_ula_start  output  1  one-cycle start pulse for divide/multiply.
_ula_done  input  1  ULA result ready.
_mem_go  output  1  one-cycle strobe qualifying the memory enable.
_reg_we  output  1  one-cycle register-file write strobe.
_pc  output  PC_WIDTH  program counter.
_busy  output  1  high in every state except IDLE and HALT.
_halted  output  1  high in HALT.
_erro  output  1  sticky error flag (ULA timeout).

Behaviour:
- Opcode is _instrucao[31:29]:
  - 000 add, 001 sub: single-cycle ULA ops.
  - 010 div, 011 mul: multi-cycle ULA ops.
  - 100 mem clear, 110 mem read, 111 mem write.
  - 101 HALT.
- Reset (async, any state): state=IDLE; _pc=0; _instrucao=0; timeout counter=0. All 1-bit outputs 0 (including _erro); _imem_addr=0.
- States:
  - IDLE: _start=1 -> _pc<=0, go to FETCH.
  - FETCH: _imem_req=1. Stay while _imem_valid=0. When _imem_valid=1: _instrucao<=_imem_data, go to DECODE.
  - DECODE (1 cycle):
    - 101 -> HALT.
    - 000/001 -> EXEC.
    - 010/011 -> WAIT_ULA; clear timeout counter.
    - 100/110/111 -> MEM.
  - EXEC (1 cycle): -> WB.
  - WAIT_ULA:
    - _ula_start=1 in the first cycle only; _ula_done is ignored in that cycle.
    - From the second cycle on: _ula_done=1 -> WB.
    - Otherwise the counter increments. When the counter reaches ULA_TIMEOUT: set _erro, go to HALT.
  - MEM (1 cycle): _mem_go=1. Opcode 110 -> WB; 100/111 -> ADVANCE.
  - WB (1 cycle): _reg_we=1, then ADVANCE.
  - ADVANCE: taken on the exit edge of WB or MEM, not a separate cycle.
    - If _pc = all ones: go to HALT with _pc unchanged (no wrap).
    - Else: _pc<=_pc+1, go to FETCH.
  - HALT: _halted=1. _start=1 -> _erro<=0, _pc<=0, go to FETCH.
- _start is ignored while _busy=1.
- All strobes are Moore outputs decoded from state; they are never asserted in the same cycle as one another.
- _instrucao changes only on the FETCH accept edge; it is stable from DECODE through the end of the instruction.
- Cycles per instruction with zero-wait fetch:
  - add/sub: 4.
  - mem read: 4.
  - mem clear/write: 3.
  - div/mul: 3 + N, where N is the number of WAIT_ULA cycles including the start cycle.
- Reset asserted mid-instruction aborts immediately; no strobe is completed.

Test Plan:
- Program {add 0x00000005, write 0xE0000000, HALT 0xA0000000} with _imem_valid tied high, pulse _start.
  - _reg_we pulses once in cycle 4 and _mem_go once in cycle 7.
  - _halted=1 after cycle 9 with _pc=2.
- Div 0x40000000, _ula_done raised 5 cycles after _ula_start.
  - Exactly one _ula_start pulse; _reg_we one cycle after done; _pc increments to 1.
- Mul, _ula_done never asserted, ULA_TIMEOUT=64.
  - _erro=1 and _halted=1 after 64 counted cycles; _reg_we never pulses.
  - Then _start -> _erro=0, _pc=0, FETCH.
- Read 0xC2000000 with _imem_valid delayed 3 cycles.
  - _imem_req held for 4 cycles and _instrucao updated only on the valid cycle.
  - _mem_go then _reg_we on consecutive cycles.
- PC_WIDTH=2, four add instructions, none a HALT.
  - After the instruction at address 3: HALT with _pc=3; no fetch from address 0.
- Assert _reset during WAIT_ULA.
  - Outputs zero asynchronously, state IDLE.
  - _start mid-execution (without reset) is ignored and does not change _pc.

Source files
------------

// File: rtl/calc_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute/memory and writeback
// for the calculator processor, with a timeout-guarded handshake to the multi-cycle ULA.
module calc_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int ULA_TIMEOUT = 64
) (
    input  logic                _clock,
    input  logic                _reset,
    input  logic                _start,
    output logic [PC_WIDTH-1:0] _imem_addr,
    output logic                _imem_req,
    input  logic                _imem_valid,
    input  logic [31:0]         _imem_data,
    output logic [31:0]         _instrucao,
    output logic                _ula_start,
    input  logic                _ula_done,
    output logic                _mem_go,
    output logic                _reg_we,
    output logic [PC_WIDTH-1:0] _pc,
    output logic                _busy,
    output logic                _halted,
    output logic                _erro
);

    localparam int CW = $clog2(ULA_TIMEOUT + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_DIV = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_CLR = 3'b100;
    localparam logic [2:0] OP_HLT = 3'b101;
    localparam logic [2:0] OP_RD  = 3'b110;
    localparam logic [2:0] OP_WR  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WAIT   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t                state_q, state_d, adv_state_s;
    logic [PC_WIDTH-1:0]   pc_q, pc_d, adv_pc_s;
    logic [31:0]           instr_q, instr_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_inc_s;
    logic                  erro_q, erro_d;
    logic                  imem_req_q, ula_start_q, mem_go_q, reg_we_q, busy_q, halted_q;
    logic [2:0]            opc_s;

    assign opc_s     = instr_q[31:29];
    assign cnt_inc_s = cnt_q + CW'(1);

    // End of an instruction: step the PC, or stop at the top of the address space instead of wrapping.
    always_comb begin
        if (&pc_q) begin
            adv_state_s = S_HALT;
            adv_pc_s    = pc_q;
        end else begin
            adv_state_s = S_FETCH;
            adv_pc_s    = pc_q + PC_WIDTH'(1);
        end
    end

    // Next-state, PC, instruction latch, ULA timeout counter and error flag.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        erro_d  = erro_q;
        case (state_q)
            S_IDLE: begin
                if (_start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (_imem_valid) begin
                    instr_d = _imem_data;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opc_s)
                    OP_HLT:         state_d = S_HALT;
                    OP_ADD, OP_SUB: state_d = S_EXEC;
                    OP_DIV, OP_MUL: begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                    OP_CLR, OP_RD, OP_WR: state_d = S_MEM;
                    default:        state_d = S_HALT;
                endcase
            end
            S_EXEC: state_d = S_WB;
            S_WAIT: begin
                // cnt_q == 0 marks the start-pulse cycle, where a stale done must be ignored
                if ((cnt_q != '0) && _ula_done) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == CW'(ULA_TIMEOUT)) begin
                        erro_d  = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_MEM: begin
                if (opc_s == OP_RD) begin
                    state_d = S_WB;
                end else begin
                    state_d = adv_state_s;
                    pc_d    = adv_pc_s;
                end
            end
            S_WB: begin
                state_d = adv_state_s;
                pc_d    = adv_pc_s;
            end
            S_HALT: begin
                if (_start) begin
                    erro_d  = 1'b0;
                    pc_d    = '0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; strobes and status are registered from the next state so they are glitch-free Moore outputs.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            instr_q     <= 32'h0000_0000;
            cnt_q       <= '0;
            erro_q      <= 1'b0;
            imem_req_q  <= 1'b0;
            ula_start_q <= 1'b0;
            mem_go_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            cnt_q       <= cnt_d;
            erro_q      <= erro_d;
            imem_req_q  <= (state_d == S_FETCH);
            ula_start_q <= (state_q == S_DECODE) && (state_d == S_WAIT);
            mem_go_q    <= (state_d == S_MEM);
            reg_we_q    <= (state_d == S_WB);
            busy_q      <= (state_d != S_IDLE) && (state_d != S_HALT);
            halted_q    <= (state_d == S_HALT);
        end
    end

    assign _imem_addr = pc_q;
    assign _pc        = pc_q;
    assign _instrucao = instr_q;
    assign _imem_req  = imem_req_q;
    assign _ula_start = ula_start_q;
    assign _mem_go    = mem_go_q;
    assign _reg_we    = reg_we_q;
    assign _busy      = busy_q;
    assign _halted    = halted_q;
    assign _erro      = erro_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: strobe events are scoreboarded against the cycle they must occur in.
module tb_calc_sequencer;

    localparam int K_US = 1;
    localparam int K_MG = 2;
    localparam int K_RW = 3;

    logic        clk, rst, start, imem_valid, ula_done;
    logic [7:0]  imem_addr, pc;
    logic        imem_req, ula_start, mem_go, reg_we, busy, halted, erro;
    logic [31:0] imem_data, instr;

    logic        start2, ula_done2;
    logic [1:0]  imem_addr2, pc2;
    logic        imem_req2, ula_start2, mem_go2, reg_we2, busy2, halted2, erro2;
    logic [31:0] imem_data2, instr2;

    logic [31:0] prog  [0:255];
    logic [31:0] prog2 [0:3];

    typedef struct { int cyc; int kind; } ev_t;
    ev_t sb[$];

    int n_cmp, n_fail, cyc, c0;
    int fetch0_2, we_2, other_2;

    assign imem_data  = prog[imem_addr];
    assign imem_data2 = prog2[imem_addr2];

    calc_sequencer #(.PC_WIDTH(8), .ULA_TIMEOUT(64)) u_dut (
        ._clock(clk), ._reset(rst), ._start(start),
        ._imem_addr(imem_addr), ._imem_req(imem_req), ._imem_valid(imem_valid), ._imem_data(imem_data),
        ._instrucao(instr), ._ula_start(ula_start), ._ula_done(ula_done),
        ._mem_go(mem_go), ._reg_we(reg_we), ._pc(pc),
        ._busy(busy), ._halted(halted), ._erro(erro)
    );

    calc_sequencer #(.PC_WIDTH(2), .ULA_TIMEOUT(64)) u_dut2 (
        ._clock(clk), ._reset(rst), ._start(start2),
        ._imem_addr(imem_addr2), ._imem_req(imem_req2), ._imem_valid(1'b1), ._imem_data(imem_data2),
        ._instrucao(instr2), ._ula_start(ula_start2), ._ula_done(ula_done2),
        ._mem_go(mem_go2), ._reg_we(reg_we2), ._pc(pc2),
        ._busy(busy2), ._halted(halted2), ._erro(erro2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input int c, input int k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        sb.push_back(e);
    endfunction

    // Advance one clock, sample just after the edge and score any strobe seen in the new cycle.
    task automatic tick();
        int ns, kind;
        ev_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("missed_strobe", cyc, e.cyc);
        end
        ns = int'(ula_start) + int'(mem_go) + int'(reg_we);
        if (ns != 0) begin
            if (ns > 1)          kind = 7;
            else if (ula_start)  kind = K_US;
            else if (mem_go)     kind = K_MG;
            else                 kind = K_RW;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", kind, 0);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind", kind, e.kind);
                chk("strobe_cycle", cyc, e.cyc);
            end
        end
        if (imem_req2 && imem_addr2 == 2'd0) fetch0_2++;
        if (reg_we2) we_2++;
        if (mem_go2 || ula_start2) other_2++;
    endtask

    task automatic wait_halt(input int bound);
        int n;
        n = 0;
        while (!halted && n < bound) begin
            tick();
            n++;
        end
        chk("halt_reached", halted, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0;
        fetch0_2 = 0; we_2 = 0; other_2 = 0;
        for (int i = 0; i < 256; i++) prog[i] = 32'hA000_0000;
        for (int i = 0; i < 4; i++) prog2[i] = 32'h0000_0010 + 32'(i);
        rst = 1'b1; start = 1'b0; imem_valid = 1'b1; ula_done = 1'b0;
        start2 = 1'b0; ula_done2 = 1'b0;
        #12;
        chk("rst_pc", pc, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_instr", instr, 0);
        chk("rst_flags", {imem_req, ula_start, mem_go, reg_we, busy, halted, erro}, 0);
        @(negedge clk);
        rst = 1'b0;

        // add / write / HALT with zero-wait fetch
        prog[0] = 32'h0000_0005; prog[1] = 32'hE000_0000; prog[2] = 32'hA000_0000;
        pulse_start();
        chk("t1_fetch_req", {busy, imem_req}, 2'b11);
        push(c0 + 3, K_RW);
        push(c0 + 6, K_MG);
        wait_halt(40);
        chk("t1_halt_cycle", cyc, c0 + 9);
        chk("t1_pc", pc, 2);
        chk("t1_instr", instr, 32'hA000_0000);

        // div with done five cycles after the start pulse
        prog[0] = 32'h4000_0000; prog[1] = 32'hA000_0000;
        pulse_start();
        push(c0 + 2, K_US);
        push(c0 + 8, K_RW);
        repeat (7) tick();
        ula_done = 1'b1;
        tick();
        ula_done = 1'b0;
        wait_halt(40);
        chk("t2_halt_cycle", cyc, c0 + 11);
        chk("t2_pc", pc, 1);
        chk("t2_erro", erro, 0);

        // mul that never completes: timeout after 64 wait cycles
        prog[0] = 32'h6000_0000;
        pulse_start();
        push(c0 + 2, K_US);
        wait_halt(200);
        chk("t3_timeout_cycle", cyc, c0 + 66);
        chk("t3_erro", erro, 1);

        // restart clears the error; read with fetch valid delayed three cycles
        prog[0] = 32'hC200_0000; prog[1] = 32'hA000_0000;
        imem_valid = 1'b0;
        pulse_start();
        chk("t4_erro_clr", erro, 0);
        chk("t4_pc0", pc, 0);
        chk("t4_req_c1", {imem_req, halted}, 2'b10);
        chk("t4_instr_hold_c1", instr, 32'h6000_0000);
        tick();
        chk("t4_req_c2", imem_req, 1);
        tick();
        chk("t4_req_c3", imem_req, 1);
        tick();
        chk("t4_req_c4", imem_req, 1);
        chk("t4_instr_hold_c4", instr, 32'h6000_0000);
        imem_valid = 1'b1;
        push(c0 + 5, K_MG);
        push(c0 + 6, K_RW);
        tick();
        chk("t4_req_drop", imem_req, 0);
        chk("t4_instr_accept", instr, 32'hC200_0000);
        wait_halt(40);
        chk("t4_halt_cycle", cyc, c0 + 9);
        chk("t4_pc", pc, 1);

        // PC_WIDTH=2: four adds, halt at the top address without wrapping
        fetch0_2 = 0; we_2 = 0; other_2 = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int n = 0; n < 100 && !halted2; n++) tick();
        chk("t5_halted", halted2, 1);
        chk("t5_pc", pc2, 3);
        chk("t5_fetch_addr0", fetch0_2, 1);
        chk("t5_reg_we_count", we_2, 4);
        chk("t5_other_strobes", other_2, 0);
        chk("t5_instr", instr2, 32'h0000_0013);
        chk("t5_status", {busy2, erro2}, 2'b00);

        // start ignored while busy, then async reset inside WAIT_ULA
        prog[0] = 32'h0000_0005; prog[1] = 32'h4000_0000;
        pulse_start();
        push(c0 + 3, K_RW);
        push(c0 + 6, K_US);
        repeat (7) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_pc_kept", pc, 1);
        chk("t6_busy", {busy, halted}, 2'b10);
        rst = 1'b1;
        #1;
        chk("t6_rst_pc", pc, 0);
        chk("t6_rst_instr", instr, 0);
        chk("t6_rst_flags", {imem_req, ula_start, mem_go, reg_we, busy, halted, erro}, 0);
        chk("t6_sb_drained", sb.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        chk("t6_idle", {busy, halted, imem_req}, 3'b000);
        chk("t6_idle_pc", pc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
